rv32i_single_cycle_core: RTL and testbench

- Single-cycle 32-bit RV32I integer CPU core, the top level of the processor datapath.
- Fetches one instruction per clock from an external combinational-read instruction memory.
- Executes it and drives a combinational data-memory request.
- Commits the register write and the PC update on the rising clock edge.
- Instruction memory and data memory are separate external blocks.

---
 rtl/rv32i_single_cycle_core.sv | 180 ++++++++++++++++++
 tb/tb_rv32i_single_cycle_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute and data-memory request all
// resolve combinationally; PC and register file commit on the rising edge.
module rv32i_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] MEM_data,
    output logic [31:0] Instr_Addr,
    output logic [31:0] MEM_addr,
    output logic [31:0] MEM_WR_out,
    output logic [2:0]  MEM_type,
    output logic        MEM_rd_en,
    output logic        MEM_wr_en
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] r_pc;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_agu;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_alu_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic [31:0] w_next_pc;
    logic [31:0] w_wb_data;
    logic        w_reg_we;
    logic        w_br_taken;
    logic        w_is_lui;
    logic        w_is_auipc;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_branch;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_opimm;
    logic        w_is_op;

    assign w_opcode = INSTRUCTION[6:0];
    assign w_rd     = INSTRUCTION[11:7];
    assign w_funct3 = INSTRUCTION[14:12];
    assign w_rs1    = INSTRUCTION[19:15];
    assign w_rs2    = INSTRUCTION[24:20];
    assign w_funct7 = INSTRUCTION[31:25];

    assign w_imm_i = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign w_imm_s = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign w_imm_b = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                      INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
    assign w_imm_u = {INSTRUCTION[31:12], 12'b0};
    assign w_imm_j = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                      INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

    // x0 is never written, so it always reads back as zero.
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_agu      = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);

    // Unlisted opcodes and reserved funct encodings all decode to nothing.
    always_comb begin
        w_is_lui    = (w_opcode == OP_LUI);
        w_is_auipc  = (w_opcode == OP_AUIPC);
        w_is_jal    = (w_opcode == OP_JAL);
        w_is_jalr   = (w_opcode == OP_JALR) && (w_funct3 == 3'b000);
        w_is_branch = (w_opcode == OP_BRANCH) && (w_funct3[2:1] != 2'b01);
        w_is_load   = (w_opcode == OP_LOAD) && (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
        w_is_store  = (w_opcode == OP_STORE) && !w_funct3[2] && (w_funct3 != 3'b011);
        w_is_op     = (w_opcode == OP_REG) &&
                      ((w_funct7 == 7'b0000000) ||
                       ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        w_is_opimm  = 1'b0;
        if (w_opcode == OP_IMM) begin
            case (w_funct3)
                3'b001:  w_is_opimm = (w_funct7 == 7'b0000000);
                3'b101:  w_is_opimm = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                default: w_is_opimm = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_alu_b = w_is_op ? w_rs2_val : w_imm_i;
        w_shamt = w_alu_b[4:0];
        w_alu   = '0;
        case (w_funct3)
            3'b000: w_alu = (w_is_op && w_funct7[5]) ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
            3'b001: w_alu = w_rs1_val << w_shamt;
            3'b010: w_alu = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu = {31'b0, w_rs1_val < w_alu_b};
            3'b100: w_alu = w_rs1_val ^ w_alu_b;
            3'b101: begin
                if (w_funct7[5]) w_alu = $signed(w_rs1_val) >>> w_shamt;
                else             w_alu = w_rs1_val >> w_shamt;
            end
            3'b110: w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_taken = (w_rs1_val <  w_rs2_val);
            3'b111:  w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_jal)
            w_next_pc = r_pc + w_imm_j;
        else if (w_is_jalr)
            w_next_pc = w_agu & ~32'd1;
        else if (w_is_branch && w_br_taken)
            w_next_pc = r_pc + w_imm_b;
    end

    always_comb begin
        w_reg_we  = 1'b1;
        w_wb_data = w_alu;
        if (w_is_lui)
            w_wb_data = w_imm_u;
        else if (w_is_auipc)
            w_wb_data = r_pc + w_imm_u;
        else if (w_is_jal || w_is_jalr)
            w_wb_data = w_pc_plus4;
        else if (w_is_load)
            w_wb_data = MEM_data;
        else if (!(w_is_op || w_is_opimm))
            w_reg_we = 1'b0;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_reg_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb_data;
        end
    end

    // Enables are gated by reset so an in-flight store is dropped at once.
    assign Instr_Addr = r_pc;
    assign MEM_addr   = w_agu;
    assign MEM_WR_out = w_rs2_val;
    assign MEM_type   = (w_is_load || w_is_store) ? w_funct3 : 3'b010;
    assign MEM_rd_en  = w_is_load && Reset;
    assign MEM_wr_en  = w_is_store && Reset;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: directed vector table, hand-written reset
// sequences, and a random instruction stream checked against an ISA-level model.
module tb_rv32i_single_cycle_core;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] INSTRUCTION = 32'h0000_0013;
    logic [31:0] MEM_data = '0;
    logic [31:0] Instr_Addr;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv32i_single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .Reset(Reset), .INSTRUCTION(INSTRUCTION), .MEM_data(MEM_data),
        .Instr_Addr(Instr_Addr), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
        .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] e_pc, e_addr, e_wdata;
    logic        e_rd, e_wr;
    logic [2:0]  e_typ;

    typedef struct {
        logic [31:0] instr, mdata, pc, addr, wdata;
        logic        rd, wr;
        logic [2:0]  typ;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return sa >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Architectural step: sets the expected bus outputs, then retires.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] md);
        logic signed [31:0] si;
        logic [31:0] a, b, ii, is_, ib, iu, ij, val, nxt;
        logic [2:0]  f3;
        logic        wb, tk;
        si  = ins;
        f3  = ins[14:12];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = si >>> 20;
        is_ = {ii[31:5], ins[11:7]};
        ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = ins & 32'hFFFF_F000;
        ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e_pc = m_pc; e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_typ = 3'b010;
        wb = 0; val = 0; tk = 0; nxt = m_pc + 4;
        case (ins[6:0])
            7'h37: begin wb = 1; val = iu; end
            7'h17: begin wb = 1; val = m_pc + iu; end
            7'h6F: begin wb = 1; val = m_pc + 4; nxt = m_pc + ij; end
            7'h67: begin wb = 1; val = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) nxt = m_pc + ib;
            end
            7'h03: begin e_rd = 1; e_addr = a + ii; e_typ = f3; wb = 1; val = md; end
            7'h23: begin e_wr = 1; e_addr = a + is_; e_wdata = b; e_typ = f3; end
            7'h13: begin wb = 1; val = alu(f3, a, ii, (f3 == 3'd5) && ins[30]); end
            7'h33: begin wb = 1; val = alu(f3, a, b, ins[30]); end
            default: ;
        endcase
        if (wb && ins[11:7] != 5'd0) m_regs[ins[11:7]] = val;
        m_pc = nxt;
    endtask

    task automatic exec(input logic [31:0] ins, input logic [31:0] md);
        @(negedge CLK);
        INSTRUCTION = ins;
        MEM_data = md;
        #1;
        model_step(ins, md);
        check("pc", Instr_Addr, e_pc);
        check("rd_en", 32'(MEM_rd_en), 32'(e_rd));
        check("wr_en", 32'(MEM_wr_en), 32'(e_wr));
        check("type", 32'(MEM_type), 32'(e_typ));
        if (e_rd || e_wr) check("addr", MEM_addr, e_addr);
        if (e_wr) check("wdata", MEM_WR_out, e_wdata);
    endtask

    function automatic vec_t tv(logic [31:0] ins, logic [31:0] pc, logic rd, logic wr,
                                logic [31:0] md, logic [31:0] addr, logic [31:0] wd, logic [2:0] typ);
        vec_t v;
        v.instr = ins; v.pc = pc; v.rd = rd; v.wr = wr; v.mdata = md;
        v.addr = addr; v.wdata = wd; v.typ = typ;
        return v;
    endfunction
    function automatic vec_t nm(logic [31:0] ins, logic [31:0] pc);
        return tv(ins, pc, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b010);
    endfunction
    function automatic vec_t sw0(int rs2, logic [31:0] pc, logic [31:0] wd);
        return tv(enc_s(0, rs2, 0, 2), pc, 1'b0, 1'b1, 32'h0, 32'h0, wd, 3'b010);
    endfunction

    function automatic logic [31:0] rand_instr();
        int k, rd, rs1, rs2, f3, imm;
        int lf[5] = '{0, 1, 2, 4, 5};
        int bf[6] = '{0, 1, 4, 5, 6, 7};
        k = $urandom_range(0, 9);
        rd = $urandom_range(0, 15); rs1 = $urandom_range(0, 15); rs2 = $urandom_range(0, 15);
        f3 = $urandom_range(0, 7);
        case (k)
            0, 1: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                               rs2, rs1, f3, rd, 'h33);
            2, 3: begin
                if (f3 == 1) imm = $urandom_range(0, 31);
                else if (f3 == 5) imm = $urandom_range(0, 31) | ($urandom_range(0, 1) << 10);
                else imm = $urandom;
                return enc_i(imm, rs1, f3, rd, 'h13);
            end
            4: return enc_u($urandom, rd, ($urandom_range(0, 1) == 1) ? 'h37 : 'h17);
            5: return enc_i($urandom, rs1, lf[$urandom_range(0, 4)], rd, 'h03);
            6: return enc_s($urandom, rs2, rs1, $urandom_range(0, 2));
            7: return enc_b($urandom, rs2, rs1, bf[$urandom_range(0, 5)]);
            8: return enc_j($urandom, rd);
            default: return enc_i($urandom, rs1, 0, rd, 'h67);
        endcase
    endfunction

    initial begin
        model_reset();
        // Reset held with a store on the bus: enables must stay low.
        INSTRUCTION = enc_s(0, 0, 0, 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); #1;
            check("rst_pc", Instr_Addr, 32'h0);
            check("rst_wr_en", 32'(MEM_wr_en), 32'h0);
            check("rst_rd_en", 32'(MEM_rd_en), 32'h0);
        end
        @(posedge CLK); #2;
        INSTRUCTION = NOP; Reset = 1'b1;
        for (int c = 0; c < 3; c++) exec(NOP, 32'h0);

        @(negedge CLK); Reset = 1'b0; #1;
        check("rst2_pc", Instr_Addr, 32'h0);
        @(posedge CLK); #2;
        INSTRUCTION = NOP; Reset = 1'b1; model_reset();

        tbl.push_back(nm(enc_i(5, 0, 0, 1, 'h13), 32'h00));
        tbl.push_back(nm(enc_i(-3, 0, 0, 2, 'h13), 32'h04));
        tbl.push_back(nm(enc_r(0, 2, 1, 0, 3, 'h33), 32'h08));
        tbl.push_back(nm(enc_r(32, 1, 2, 0, 4, 'h33), 32'h0C));
        tbl.push_back(nm(enc_r(0, 1, 2, 2, 5, 'h33), 32'h10));
        tbl.push_back(nm(enc_r(0, 1, 2, 3, 6, 'h33), 32'h14));
        tbl.push_back(nm(enc_i('h401, 2, 5, 7, 'h13), 32'h18));
        tbl.push_back(nm(enc_i(7, 0, 0, 0, 'h13), 32'h1C));
        tbl.push_back(sw0(3, 32'h20, 32'h0000_0002));
        tbl.push_back(sw0(4, 32'h24, 32'hFFFF_FFF8));
        tbl.push_back(sw0(5, 32'h28, 32'h0000_0001));
        tbl.push_back(sw0(6, 32'h2C, 32'h0000_0000));
        tbl.push_back(sw0(7, 32'h30, 32'hFFFF_FFFE));
        tbl.push_back(sw0(0, 32'h34, 32'h0000_0000));
        tbl.push_back(nm(enc_i('h80, 0, 0, 1, 'h13), 32'h38));
        tbl.push_back(nm(enc_u('h12345, 2, 'h37), 32'h3C));
        tbl.push_back(nm(enc_i('h6F0, 2, 0, 2, 'h13), 32'h40));
        tbl.push_back(tv(enc_s(0, 2, 1, 2), 32'h44, 0, 1, 32'h0, 32'h80, 32'h1234_56F0, 3'b010));
        tbl.push_back(tv(enc_i(0, 1, 0, 3, 'h03), 32'h48, 1, 0, 32'hFFFF_FFF0, 32'h80, 32'h0, 3'b000));
        tbl.push_back(tv(enc_i(0, 1, 4, 4, 'h03), 32'h4C, 1, 0, 32'h0000_00F0, 32'h80, 32'h0, 3'b100));
        tbl.push_back(tv(enc_s(4, 3, 1, 2), 32'h50, 0, 1, 32'h0, 32'h84, 32'hFFFF_FFF0, 3'b010));
        tbl.push_back(tv(enc_s(-2, 4, 1, 1), 32'h54, 0, 1, 32'h0, 32'h7E, 32'h0000_00F0, 3'b001));
        tbl.push_back(nm(enc_b(8, 1, 1, 0), 32'h58));
        tbl.push_back(nm(enc_b(8, 1, 1, 1), 32'h60));
        tbl.push_back(nm(enc_i(-1, 0, 0, 8, 'h13), 32'h64));
        tbl.push_back(nm(enc_i(1, 0, 0, 9, 'h13), 32'h68));
        tbl.push_back(nm(enc_b(16, 9, 8, 4), 32'h6C));
        tbl.push_back(nm(enc_b(16, 9, 8, 6), 32'h7C));
        tbl.push_back(nm(enc_b(-64, 9, 8, 7), 32'h80));
        tbl.push_back(nm(enc_j('h20, 1), 32'h40));
        tbl.push_back(nm(enc_i(3, 1, 0, 2, 'h67), 32'h60));
        tbl.push_back(nm(enc_u('hABCDE, 5, 'h37), 32'h46));
        tbl.push_back(sw0(2, 32'h4A, 32'h0000_0064));
        tbl.push_back(sw0(1, 32'h4E, 32'h0000_0044));
        tbl.push_back(sw0(5, 32'h52, 32'hABCD_E000));
        tbl.push_back(nm(enc_i(0, 1, 0, 1, 'h67), 32'h56));
        tbl.push_back(sw0(1, 32'h44, 32'h0000_005A));
        tbl.push_back(nm(32'hFFFF_FFFF, 32'h48));
        tbl.push_back(sw0(1, 32'h4C, 32'h0000_005A));
        tbl.push_back(nm(enc_j('hB0, 0), 32'h50));
        tbl.push_back(nm(enc_u(1, 6, 'h17), 32'h100));
        tbl.push_back(sw0(6, 32'h104, 32'h0000_1100));
        tbl.push_back(nm(NOP, 32'h108));

        foreach (tbl[i]) begin
            @(negedge CLK);
            INSTRUCTION = tbl[i].instr;
            MEM_data = tbl[i].mdata;
            #1;
            check($sformatf("v%0d_pc", i), Instr_Addr, tbl[i].pc);
            check($sformatf("v%0d_rd_en", i), 32'(MEM_rd_en), 32'(tbl[i].rd));
            check($sformatf("v%0d_wr_en", i), 32'(MEM_wr_en), 32'(tbl[i].wr));
            check($sformatf("v%0d_type", i), 32'(MEM_type), 32'(tbl[i].typ));
            if (tbl[i].rd || tbl[i].wr) check($sformatf("v%0d_addr", i), MEM_addr, tbl[i].addr);
            if (tbl[i].wr) check($sformatf("v%0d_wdata", i), MEM_WR_out, tbl[i].wdata);
            model_step(tbl[i].instr, tbl[i].mdata);
        end

        for (int n = 0; n < 400; n++) exec(rand_instr(), $urandom);
        for (int r = 1; r < 32; r++) exec(enc_s(0, r, 0, 2), 32'h0);

        // Reset arriving while a store is on the bus.
        exec(enc_i('h55, 0, 0, 1, 'h13), 32'h0);
        @(negedge CLK);
        INSTRUCTION = enc_s(0, 1, 0, 2);
        #1;
        check("mid_wr_before", 32'(MEM_wr_en), 32'h1);
        check("mid_wdata_before", MEM_WR_out, 32'h55);
        Reset = 1'b0;
        #1;
        check("mid_wr_en", 32'(MEM_wr_en), 32'h0);
        check("mid_pc", Instr_Addr, 32'h0);
        @(posedge CLK); #1;
        check("mid_pc_hold", Instr_Addr, 32'h0);
        check("mid_wr_hold", 32'(MEM_wr_en), 32'h0);
        @(posedge CLK); #2;
        INSTRUCTION = NOP; Reset = 1'b1; model_reset();
        for (int r = 1; r < 32; r++) exec(enc_s(0, r, 0, 2), 32'h0);

        exec(32'hFFFF_FFFF, 32'h0);
        exec(32'h0000_0073, 32'h0);
        exec(32'h0000_000F, 32'h0);
        exec(enc_s(0, 1, 0, 2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
